// File: rtl/muldiv_result_buffer_pkg.sv
// muldiv_result_buffer_pkg
//   Shared types and constants for the MD combo result buffer.
//   - MD_RESULT_BUF_DEPTH : default number of buffered results
//   - MD_XLEN/MD_RRN_W/MD_ARN_W : field widths of a CDB entry
//   - cdb_entry_t         : one completed result (value + rename/arch tags)
//   - result_buf_state_t  : broadcast sequencing states
package muldiv_result_buffer_pkg;

  localparam int MD_RESULT_BUF_DEPTH = 4;
  localparam int MD_XLEN             = 32;
  localparam int MD_RRN_W            = 6;
  localparam int MD_ARN_W            = 5;

  typedef struct packed {
    logic [MD_XLEN-1:0]  result;
    logic [MD_RRN_W-1:0] rrn;
    logic [MD_ARN_W-1:0] arn;
  } cdb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    BROADCAST
  } result_buf_state_t;

endpackage

// File: rtl/muldiv_result_buffer_sync_fifo.sv
// muldiv_result_buffer_sync_fifo
//   Small synchronous FIFO of CDB entries with first-word-fall-through head.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     flush       : discard all entries (lower priority than reset)
//     push        : write push_data at the tail (caller guarantees !full)
//     push_data   : entry to write
//     pop         : drop the head entry (caller guarantees !empty)
//     head        : current head entry, valid whenever !empty
//     count       : number of stored entries (0..DEPTH)
//     full, empty : decoded from count
module muldiv_result_buffer_sync_fifo
  import muldiv_result_buffer_pkg::*;
#(
  parameter int  DEPTH   = MD_RESULT_BUF_DEPTH,
  parameter type entry_t = cdb_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  // Push and pop together leave count unchanged while both pointers move.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only slots between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/muldiv_result_buffer.sv
// muldiv_result_buffer
//   Result-side stage behind the MD execution unit. Completed results are
//   queued, the CDB is requested while anything is queued, and one entry is
//   broadcast per granted cycle (one cycle after the grant). The MD station
//   is stalled through o_ready so nothing is lost while the bus is busy.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     i_flush           : mispredict flush, discards all queued results
//     i_valid, i_result, i_rrn, i_arn : incoming result from the MD unit
//     o_ready           : buffer has space (registered count only)
//     o_get_bus         : CDB request, from registered state and i_flush
//     i_bus_granted     : arbiter grant, same cycle as the request
//     o_cdb_valid, o_cdb_result, o_cdb_rrn, o_cdb_arn : registered broadcast
//   XLEN/RRN_W/ARN_W must match the widths of cdb_entry_t in the package.
module muldiv_result_buffer
  import muldiv_result_buffer_pkg::*;
#(
  parameter int DEPTH = MD_RESULT_BUF_DEPTH,
  parameter int XLEN  = MD_XLEN,
  parameter int RRN_W = MD_RRN_W,
  parameter int ARN_W = MD_ARN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [XLEN-1:0]  i_result,
  input  logic [RRN_W-1:0] i_rrn,
  input  logic [ARN_W-1:0] i_arn,
  output logic             o_ready,
  output logic             o_get_bus,
  input  logic             i_bus_granted,
  output logic             o_cdb_valid,
  output logic [XLEN-1:0]  o_cdb_result,
  output logic [RRN_W-1:0] o_cdb_rrn,
  output logic [ARN_W-1:0] o_cdb_arn
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t        push_entry;
  cdb_entry_t        head_entry;
  cdb_entry_t        cdb_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  result_buf_state_t state;

  // Space is judged on the registered count: a pop in the same cycle does
  // not make room, which keeps o_ready free of any path from the grant.
  assign o_ready    = !fifo_full;
  assign o_get_bus  = !fifo_empty && !i_flush;
  assign push       = i_valid && o_ready && !i_flush;
  assign pop        = o_get_bus && i_bus_granted;
  assign push_entry = '{result: i_result, rrn: i_rrn, arn: i_arn};

  muldiv_result_buffer_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cdb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + 1'b1;
    end else if (!push && pop) begin
      count_next = fifo_count - 1'b1;
    end
  end

  // Broadcast sequencer. A pop loads the head into the CDB register and
  // enters BROADCAST for exactly one cycle (or stays there on back-to-back
  // grants). In every other cycle the CDB register is cleared so the bus
  // never carries stale data. A flush cannot retract a broadcast already
  // held in cdb_q; it only blocks the next one.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      state <= IDLE;
      cdb_q <= '0;
    end else if (pop) begin
      state <= BROADCAST;
      cdb_q <= head_entry;
    end else begin
      cdb_q <= '0;
      if (count_next != '0) begin
        state <= REQUEST;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign o_cdb_valid  = (state == BROADCAST);
  assign o_cdb_result = cdb_q.result;
  assign o_cdb_rrn    = cdb_q.rrn;
  assign o_cdb_arn    = cdb_q.arn;

  // The station must honour o_ready; a result offered while full is dropped.
  always @(posedge clk) begin
    if (!reset && !i_flush && i_valid) begin
      assert (o_ready)
        else $warning("muldiv_result_buffer: result dropped, buffer full");
    end
  end

endmodule

// File: tb/tb_muldiv_result_buffer.sv
// tb_muldiv_result_buffer
//   Table of hand-derived vectors plus short sequences for the multi-cycle
//   corners. A queue model tracks buffer contents; every popped entry is
//   pushed to a broadcast scoreboard and must appear on the CDB exactly one
//   cycle after its grant.
module tb_muldiv_result_buffer;
  import muldiv_result_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_result;
  logic [5:0]  i_rrn;
  logic [4:0]  i_arn;
  logic        o_ready;
  logic        o_get_bus;
  logic        i_bus_granted;
  logic        o_cdb_valid;
  logic [31:0] o_cdb_result;
  logic [5:0]  o_cdb_rrn;
  logic [4:0]  o_cdb_arn;

  int checks = 0;
  int errors = 0;

  cdb_entry_t fifo_q[$];
  cdb_entry_t bcast_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic [5:0]  rrn;
    logic [4:0]  arn;
    logic        grant;
    logic        flush;
    logic        exp_ready;
    logic        exp_get_bus;
    logic        exp_cdb_valid;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_result_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .i_result      (i_result),
    .i_rrn         (i_rrn),
    .i_arn         (i_arn),
    .o_ready       (o_ready),
    .o_get_bus     (o_get_bus),
    .i_bus_granted (i_bus_granted),
    .o_cdb_valid   (o_cdb_valid),
    .o_cdb_result  (o_cdb_result),
    .o_cdb_rrn     (o_cdb_rrn),
    .o_cdb_arn     (o_cdb_arn)
  );

  function automatic vec_t make_vec(logic v, logic [31:0] r, logic [5:0] rr,
                                    logic [4:0] ar, logic g, logic f,
                                    logic er, logic eg, logic ec,
                                    logic [31:0] eres);
    vec_t t;
    t.valid = v; t.result = r; t.rrn = rr; t.arn = ar; t.grant = g;
    t.flush = f; t.exp_ready = er; t.exp_get_bus = eg;
    t.exp_cdb_valid = ec; t.exp_result = eres;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock edge with the current pins: update the model, then compare
  // the DUT outputs against it 1ns after the edge.
  task automatic apply_stimulus();
    bit         m_ready, m_get, do_push, do_pop;
    cdb_entry_t e;
    cdb_entry_t exp_e;
    m_ready = (fifo_q.size() < 4);
    m_get   = (fifo_q.size() != 0) && !i_flush;
    do_push = i_valid && m_ready && !i_flush;
    do_pop  = m_get && i_bus_granted;
    @(posedge clk);
    if (reset) begin
      fifo_q.delete();
      bcast_q.delete();
    end else if (i_flush) begin
      fifo_q.delete();
    end else begin
      if (do_pop) bcast_q.push_back(fifo_q.pop_front());
      if (do_push) begin
        e.result = i_result;
        e.rrn    = i_rrn;
        e.arn    = i_arn;
        fifo_q.push_back(e);
      end
    end
    #1;
    check_output("ready", {31'b0, o_ready}, {31'b0, fifo_q.size() < 4});
    check_output("get_bus", {31'b0, o_get_bus},
                 {31'b0, (fifo_q.size() != 0) && !i_flush});
    check_output("cdb_valid", {31'b0, o_cdb_valid}, {31'b0, bcast_q.size() != 0});
    if (bcast_q.size() != 0) begin
      exp_e = bcast_q.pop_front();
      check_output("cdb_result", o_cdb_result, exp_e.result);
      check_output("cdb_rrn", {26'b0, o_cdb_rrn}, {26'b0, exp_e.rrn});
      check_output("cdb_arn", {27'b0, o_cdb_arn}, {27'b0, exp_e.arn});
    end else begin
      check_output("cdb_result_idle", o_cdb_result, 32'h0);
      check_output("cdb_rrn_idle", {26'b0, o_cdb_rrn}, 32'h0);
      check_output("cdb_arn_idle", {27'b0, o_cdb_arn}, 32'h0);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic g,
                        input logic f);
    i_valid       = v;
    i_result      = r;
    i_rrn         = r[5:0];
    i_arn         = r[4:0];
    i_bus_granted = g;
    i_flush       = f;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 32'hdead, 1'b0, 1'b0);

    // Reset held three cycles while the MD unit keeps offering a result.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output("reset_ready", {31'b0, o_ready}, 32'h1);
      check_output("reset_get_bus", {31'b0, o_get_bus}, 32'h0);
      check_output("reset_cdb_valid", {31'b0, o_cdb_valid}, 32'h0);
      check_output("reset_cdb_result", o_cdb_result, 32'h0);
    end
    reset = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus();

    // valid result rrn arn grant flush | ready get_bus cdb_valid cdb_result
    vecs.push_back(make_vec(1, 32'h42, 6'd5, 5'd3, 1, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 0, 1, 32'h42));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h11, 6'd1, 5'd1, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h12, 6'd2, 5'd2, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h13, 6'd3, 5'd3, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h14, 6'd4, 5'd4, 1, 1, 1, 0, 0, 32'h0));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h1,  6'd1, 5'd1, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h2,  6'd2, 5'd2, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h3,  6'd3, 5'd3, 0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h4,  6'd4, 5'd4, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(make_vec(1, 32'h5,  6'd5, 5'd5, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 1, 1, 32'h1));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 1, 1, 32'h2));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 1, 1, 32'h3));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 0, 1, 32'h4));
    vecs.push_back(make_vec(0, 32'h0,  6'd0, 5'd0, 1, 0, 1, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      i_valid       = vecs[i].valid;
      i_result      = vecs[i].result;
      i_rrn         = vecs[i].rrn;
      i_arn         = vecs[i].arn;
      i_bus_granted = vecs[i].grant;
      i_flush       = vecs[i].flush;
      apply_stimulus();
      check_output($sformatf("vec%0d_ready", i), {31'b0, o_ready},
                   {31'b0, vecs[i].exp_ready});
      check_output($sformatf("vec%0d_get_bus", i), {31'b0, o_get_bus},
                   {31'b0, vecs[i].exp_get_bus});
      check_output($sformatf("vec%0d_cdb_valid", i), {31'b0, o_cdb_valid},
                   {31'b0, vecs[i].exp_cdb_valid});
      check_output($sformatf("vec%0d_cdb_result", i), o_cdb_result,
                   vecs[i].exp_result);
    end

    // One entry, grant withheld for 10 cycles, then granted.
    set_in(1'b1, 32'h77, 1'b0, 1'b0);
    apply_stimulus();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("hold_get_bus", {31'b0, o_get_bus}, 32'h1);
      check_output("hold_no_bcast", {31'b0, o_cdb_valid}, 32'h0);
    end
    i_bus_granted = 1'b1;
    apply_stimulus();
    check_output("late_grant_bcast", o_cdb_result, 32'h77);
    i_bus_granted = 1'b0;
    apply_stimulus();

    // Ten back-to-back results with a permanent grant; pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      apply_stimulus();
      check_output("stream_ready", {31'b0, o_ready}, 32'h1);
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    apply_stimulus();
    apply_stimulus();

    // Flush while a broadcast is already registered: it still completes.
    set_in(1'b1, 32'ha1, 1'b0, 1'b0);
    apply_stimulus();
    set_in(1'b1, 32'ha2, 1'b0, 1'b0);
    apply_stimulus();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    apply_stimulus();
    i_flush = 1'b1;
    #1;
    check_output("flush_cycle_cdb_valid", {31'b0, o_cdb_valid}, 32'h1);
    check_output("flush_cycle_cdb_result", o_cdb_result, 32'ha1);
    check_output("flush_cycle_get_bus", {31'b0, o_get_bus}, 32'h0);
    apply_stimulus();
    check_output("after_flush_cdb_valid", {31'b0, o_cdb_valid}, 32'h0);
    i_flush = 1'b0;
    apply_stimulus();
    check_output("after_flush_get_bus", {31'b0, o_get_bus}, 32'h0);

    // Reset asserted while a broadcast is on the bus.
    set_in(1'b1, 32'hb1, 1'b1, 1'b0);
    apply_stimulus();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    apply_stimulus();
    check_output("pre_reset_bcast", {31'b0, o_cdb_valid}, 32'h1);
    reset = 1'b1;
    apply_stimulus();
    check_output("mid_bcast_reset_valid", {31'b0, o_cdb_valid}, 32'h0);
    reset = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
